// File: rtl/lcd_pkg.sv
// Shared constants for the LCD register bank: register map, control/status bit
// positions, row geometry and the byte-lane merge helper.
package lcd_pkg;

    localparam int NIB_W    = 4;
    localparam int ROW_NIBS = 16;
    localparam int ROW_W    = NIB_W * ROW_NIBS;
    localparam int WORD_W   = 16;
    localparam int ADR_W    = 4;

    localparam logic [ADR_W-1:0] ADR_ROW1_0 = 4'h0;
    localparam logic [ADR_W-1:0] ADR_ROW1_1 = 4'h1;
    localparam logic [ADR_W-1:0] ADR_ROW1_2 = 4'h2;
    localparam logic [ADR_W-1:0] ADR_ROW1_3 = 4'h3;
    localparam logic [ADR_W-1:0] ADR_ROW2_0 = 4'h4;
    localparam logic [ADR_W-1:0] ADR_ROW2_1 = 4'h5;
    localparam logic [ADR_W-1:0] ADR_ROW2_2 = 4'h6;
    localparam logic [ADR_W-1:0] ADR_ROW2_3 = 4'h7;
    localparam logic [ADR_W-1:0] ADR_M1     = 4'h8;
    localparam logic [ADR_W-1:0] ADR_M2     = 4'h9;
    localparam logic [ADR_W-1:0] ADR_CTRL   = 4'hA;
    localparam logic [ADR_W-1:0] ADR_STAT   = 4'hB;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int STAT_PEND   = 0;

    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] cur,
        input logic [WORD_W-1:0] wdat,
        input logic [1:0]        sel
    );
        logic [WORD_W-1:0] res;
        res = cur;
        if (sel[0]) res[7:0]  = wdat[7:0];
        if (sel[1]) res[15:8] = wdat[15:8];
        return res;
    endfunction

endpackage

// File: rtl/lcd_zblank.sv
// Leading-zero blank mask for one LCD row; nibble 0 always stays enabled.
// Only built when LCD_ZBLANK_EN is defined.
`ifdef LCD_ZBLANK_EN
module lcd_zblank
    import lcd_pkg::*;
(
    input  logic [ROW_W-1:0]    row,
    output logic [ROW_NIBS-1:0] mask
);

    logic run;

    always_comb begin
        mask = '1;
        run  = 1'b1;
        for (int k = ROW_NIBS - 1; k >= 1; k--) begin
            if (run && (row[k*NIB_W +: NIB_W] == '0)) begin
                mask[k] = 1'b0;
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/lcd_wb_regs.sv
// Wishbone register bank for the 2x16 LCD hex driver; shadows commit atomically.
// Define LCD_ZBLANK_EN to blank leading zero digits in the committed masks.
module lcd_wb_regs
    import lcd_pkg::*;
#(
    parameter int          REFRESH_DIV = 24,
    parameter logic [15:0] CTRL_RST    = 16'h0002
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [ADR_W-1:0]    wb_adr_i,
    input  logic [WORD_W-1:0]   wb_dat_i,
    output logic [WORD_W-1:0]   wb_dat_o,
    input  logic [1:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic                wb_ack_o,
    output logic [ROW_W-1:0]    f1,
    output logic [ROW_W-1:0]    f2,
    output logic [ROW_NIBS-1:0] m1,
    output logic [ROW_NIBS-1:0] m2
);

    logic [ROW_W-1:0]       row1_sh;
    logic [ROW_W-1:0]       row2_sh;
    logic [WORD_W-1:0]      m1_sh;
    logic [WORD_W-1:0]      m2_sh;
    logic                   auto_en;
    logic                   pending;
    logic [REFRESH_DIV-1:0] cnt;

    logic                   acc;
    logic                   wr;
    logic                   data_wr;
    logic                   commit_cmd;
    logic                   tick;
    logic                   commit;
    logic [5:0]             word_lsb;
    logic [WORD_W-1:0]      rd_data;
    logic [ROW_NIBS-1:0]    m1_next;
    logic [ROW_NIBS-1:0]    m2_next;

    assign acc        = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr         = acc & wb_we_i;
    assign data_wr    = wr & (wb_adr_i <= ADR_M2);
    assign commit_cmd = wr & (wb_adr_i == ADR_CTRL) & wb_sel_i[0] & wb_dat_i[CTRL_COMMIT];
    assign tick       = &cnt;
    assign commit     = commit_cmd | (tick & auto_en & pending);
    assign word_lsb   = {wb_adr_i[1:0], 4'b0000};

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_ROW1_0, ADR_ROW1_1, ADR_ROW1_2, ADR_ROW1_3: rd_data = row1_sh[word_lsb +: WORD_W];
            ADR_ROW2_0, ADR_ROW2_1, ADR_ROW2_2, ADR_ROW2_3: rd_data = row2_sh[word_lsb +: WORD_W];
            ADR_M1:   rd_data = m1_sh;
            ADR_M2:   rd_data = m2_sh;
            ADR_CTRL: rd_data[CTRL_AUTO] = auto_en;
            ADR_STAT: rd_data[STAT_PEND] = pending;
            default:  rd_data = '0;
        endcase
    end

`ifdef LCD_ZBLANK_EN
    logic [ROW_NIBS-1:0] zb1;
    logic [ROW_NIBS-1:0] zb2;

    lcd_zblank u_zb1 (.row(row1_sh), .mask(zb1));
    lcd_zblank u_zb2 (.row(row2_sh), .mask(zb2));

    assign m1_next = m1_sh & zb1;
    assign m2_next = m2_sh & zb2;
`else
    assign m1_next = m1_sh;
    assign m2_next = m2_sh;
`endif

    // Commit samples the shadows before this cycle's write lands, so a
    // colliding data write stays pending for the next commit.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            row1_sh  <= '0;
            row2_sh  <= '0;
            m1_sh    <= '0;
            m2_sh    <= '0;
            auto_en  <= CTRL_RST[CTRL_AUTO];
            pending  <= 1'b0;
            cnt      <= '0;
            f1       <= '0;
            f2       <= '0;
            m1       <= '0;
            m2       <= '0;
        end else begin
            wb_ack_o <= acc;
            wb_dat_o <= acc ? rd_data : '0;
            cnt      <= cnt + REFRESH_DIV'(1);

            if (wr) begin
                case (wb_adr_i)
                    ADR_ROW1_0, ADR_ROW1_1, ADR_ROW1_2, ADR_ROW1_3:
                        row1_sh[word_lsb +: WORD_W] <= lane_merge(row1_sh[word_lsb +: WORD_W], wb_dat_i, wb_sel_i);
                    ADR_ROW2_0, ADR_ROW2_1, ADR_ROW2_2, ADR_ROW2_3:
                        row2_sh[word_lsb +: WORD_W] <= lane_merge(row2_sh[word_lsb +: WORD_W], wb_dat_i, wb_sel_i);
                    ADR_M1:   m1_sh <= lane_merge(m1_sh, wb_dat_i, wb_sel_i);
                    ADR_M2:   m2_sh <= lane_merge(m2_sh, wb_dat_i, wb_sel_i);
                    ADR_CTRL: if (wb_sel_i[0]) auto_en <= wb_dat_i[CTRL_AUTO];
                    default:  ;
                endcase
            end

            if (data_wr) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end

            if (commit) begin
                f1 <= row1_sh;
                f2 <= row2_sh;
                m1 <= m1_next;
                m2 <= m2_next;
            end
        end
    end

endmodule

// File: tb/tb_lcd_wb_regs.sv
// Scoreboard bench for lcd_wb_regs with a 16-cycle refresh tick.
// Bus reads queue their expected data; a monitor checks each ack against the queue.
module tb_lcd_wb_regs;
    import lcd_pkg::*;

    localparam int TB_DIV = 4;

`ifdef LCD_ZBLANK_EN
    localparam logic [15:0] EXP_M1_AUTO = 16'h000F;
`else
    localparam logic [15:0] EXP_M1_AUTO = 16'hFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [3:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [63:0] f1, f2;
    logic [15:0] m1, m2;

    logic [TB_DIV-1:0] mcnt;

    typedef struct {
        bit          rd;
        logic [15:0] exp;
        string       name;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int fails  = 0;

    lcd_wb_regs #(.REFRESH_DIV(TB_DIV), .CTRL_RST(16'h0002)) dut (
        .clk(clk), .rst_(rst_),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .f1(f1), .f2(f2), .m1(m1), .m2(m2)
    );

    always #5 clk = ~clk;

    // Reference refresh counter: free-running from reset release.
    always @(posedge clk) begin
        if (!rst_) mcnt <= '0;
        else       mcnt <= mcnt + 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ && wb_ack_o) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ack: got ack with empty queue expected none");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.rd) chk(e.name, {48'h0, wb_dat_o}, {48'h0, e.exp});
            end
        end
    end

    task automatic bus_start(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                             input bit we, input logic [15:0] exp, input string name);
        exp_t e;
        e.rd = !we;
        e.exp = exp;
        e.name = name;
        q.push_back(e);
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
    endtask

    task automatic bus_finish(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack_o) got = 1;
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        if (!got) begin
            checks++;
            fails++;
            $display("FAIL %s_ack: got no ack expected ack within 8 cycles", name);
            if (q.size() != 0) void'(q.pop_back());
        end
    endtask

    task automatic wr(input logic [3:0] adr, input logic [15:0] dat, input logic [1:0] sel, input string name);
        @(negedge clk);
        bus_start(adr, dat, sel, 1'b1, 16'h0, name);
        bus_finish(name);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [15:0] exp, input string name);
        @(negedge clk);
        bus_start(adr, 16'h0, 2'b11, 1'b0, exp, name);
        bus_finish(name);
    endtask

    // Waits until the cycle in which the counter sits at all-ones (tick high).
    task automatic wait_tick_cycle(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mcnt == '1) seen = 1;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL %s_tick: got no tick expected one within 40 cycles", name);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        repeat (3) @(negedge clk);

        // Reset asserted while a read of addr 0 is outstanding
        bus_start(ADR_ROW1_0, 16'h0, 2'b11, 1'b0, 16'h0, "dropped");
        void'(q.pop_back());
        rst_ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", {63'h0, wb_ack_o}, 64'h0);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        rst_ = 1'b1;
        chk("rst_f1", f1, 64'h0);
        chk("rst_f2", f2, 64'h0);
        chk("rst_m1", {48'h0, m1}, 64'h0);
        chk("rst_m2", {48'h0, m2}, 64'h0);
        chk("rst_dat_o", {48'h0, wb_dat_o}, 64'h0);
        rd(ADR_CTRL, 16'h0002, "rst_ctrl");
        rd(ADR_STAT, 16'h0000, "rst_stat");

        // Byte lanes with AUTO off
        wr(ADR_CTRL, 16'h0000, 2'b11, "auto_off");
        wr(ADR_ROW1_0, 16'h1234, 2'b11, "w_row1_0");
        wr(ADR_ROW1_0, 16'hAB00, 2'b10, "w_row1_0_hi");
        rd(ADR_ROW1_0, 16'hAB34, "lane_merge");
        rd(ADR_STAT, 16'h0001, "stat_pend");
        chk("f1_uncommitted", f1, 64'h0);

        // Explicit commit
        wr(ADR_CTRL, 16'h0001, 2'b11, "commit");
        chk("f1_committed", f1, 64'h0000_0000_0000_AB34);
        rd(ADR_STAT, 16'h0000, "stat_cleared");
        rd(ADR_CTRL, 16'h0000, "ctrl_after_commit");

        // Unmapped addresses: read 0, writes ignored, no pending
        wr(4'hE, 16'hFFFF, 2'b11, "w_hole");
        rd(4'hE, 16'h0000, "rd_hole");
        rd(4'hC, 16'h0000, "rd_hole_c");
        rd(ADR_STAT, 16'h0000, "stat_hole");

        // Auto commit on the tick
        wr(ADR_CTRL, 16'h0002, 2'b11, "auto_on");
        wr(ADR_M1, 16'hFFFF, 2'b11, "w_m1");
        wait_tick_cycle("auto");
        chk("m1_before_tick", {48'h0, m1}, 64'h0);
        @(posedge clk);
        #1;
        chk("m1_after_tick", {48'h0, m1}, {48'h0, EXP_M1_AUTO});
        rd(ADR_M1, 16'hFFFF, "rd_m1_shadow");

        // AUTO off: no auto commit
        wr(ADR_CTRL, 16'h0000, 2'b11, "auto_off2");
        wr(ADR_M2, 16'h00FF, 2'b11, "w_m2");
        repeat (40) @(negedge clk);
        chk("m2_no_auto", {48'h0, m2}, 64'h0);
        rd(ADR_STAT, 16'h0001, "stat_still_pend");

        // Data write colliding with a tick commit
        wr(ADR_CTRL, 16'h0002, 2'b11, "auto_on2");
        wr(ADR_ROW2_1, 16'h2222, 2'b11, "w_row2_1");
        wait_tick_cycle("collide");
        bus_start(ADR_ROW2_0, 16'h3333, 2'b11, 1'b1, 16'h0, "w_row2_0");
        bus_finish("w_row2_0");
        chk("f2_collision", f2, 64'h0000_0000_2222_0000);
        rd(ADR_STAT, 16'h0001, "stat_collision");
        wait_tick_cycle("collide2");
        @(posedge clk);
        #1;
        chk("f2_next_tick", f2, 64'h0000_0000_2222_3333);
        rd(ADR_STAT, 16'h0000, "stat_after_tick");

`ifdef LCD_ZBLANK_EN
        wr(ADR_CTRL, 16'h0000, 2'b11, "zb_auto_off");
        wr(ADR_ROW1_0, 16'h00A0, 2'b11, "zb_w0");
        wr(ADR_ROW1_1, 16'h0000, 2'b11, "zb_w1");
        wr(ADR_ROW1_2, 16'h0000, 2'b11, "zb_w2");
        wr(ADR_ROW1_3, 16'h0000, 2'b11, "zb_w3");
        wr(ADR_CTRL, 16'h0001, 2'b01, "zb_commit");
        chk("zb_m1_a0", {48'h0, m1}, 64'h0003);
        wr(ADR_ROW1_0, 16'h0000, 2'b11, "zb_w0_zero");
        wr(ADR_CTRL, 16'h0001, 2'b01, "zb_commit2");
        chk("zb_m1_zero", {48'h0, m1}, 64'h0001);
        rd(ADR_M1, 16'hFFFF, "zb_rd_m1");
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_wb_regs.md
Name: lcd_wb_regs

Overview:
Wishbone-slave register bank that feeds the 2x16 character LCD hex driver with its row data (f1/f2) and digit masks (m1/m2). The CPU writes into shadow registers. The shadow contents are committed to the display-facing outputs atomically, either by explicit command or on a slow refresh tick, so the LCD scanner never shows a half-updated row. It sits between the system Wishbone bus and the LCD display driver.

Parameters:
REFRESH_DIV, 24, refresh-tick period is 2^REFRESH_DIV clk cycles (~0.17 s at 100 MHz)
CTRL_RST, 16'h0002, reset value of the control register (auto-commit enabled)

Ports:
clk  in  1  system clock, 100 MHz
rst_  in  1  synchronous active-low reset
wb_adr_i  in  4  word address (byte address bits [4:1])
wb_dat_i  in  16  write data
wb_dat_o  out  16  read data
wb_sel_i  in  2  byte lane selects
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_ack_o  out  1  acknowledge
f1  out  64  row 1 nibbles to the LCD driver (nibble k = f1[4k+3:4k])
f2  out  64  row 2 nibbles
m1  out  16  row 1 digit enables (bit k enables nibble k)
m2  out  16  row 2 digit enables

Behaviour:
- Reset: one clock, synchronous. rst_ low at a posedge clears f1, f2, m1, m2, all shadows, pending, tick counter, wb_ack_o and wb_dat_o to 0, and loads ctrl to CTRL_RST. This applies mid-transfer too: any in-flight access is dropped with no ack.
- Register map (word address):
  - 0-3: row1 shadow words 0..3, word n maps to f1[16n+15:16n]
  - 4-7: row2 shadow words 0..3
  - 8: m1 shadow
  - 9: m2 shadow
  - A: ctrl. Bit0 is COMMIT: write-1 commits, not stored, reads 0. Bit1 is AUTO, read/write.
  - B: status, read-only. Bit0 is pending.
  - C-F: read 0, writes ignored, still acked.
- Handshake:
  - wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o, giving a single-cycle ack one clock after the request.
  - The write takes effect on the acking edge, and only on the lanes enabled by wb_sel_i.
  - wb_dat_o is registered and valid while wb_ack_o is high. Reads return shadow values, not outputs.
- Pending: set on any acked write to addresses 0-9, including sel=00. Cleared on commit. If a data write and a commit occur in the same cycle, pending stays 1.
- Commit: copies all shadows to f1/f2/m1/m2 in one clock, so outputs change on the edge after the trigger. Triggers:
  - (a) an acked ctrl write with wb_dat_i[0]=1 and wb_sel_i[0]=1; fires regardless of AUTO.
  - (b) tick & AUTO & pending.
  - Simultaneous triggers produce a single copy.
  - A commit copies shadow values as they were before that cycle's write. A data write in the commit cycle is therefore not visible on the outputs and leaves pending set.
- Tick counter: REFRESH_DIV-bit free-running up-counter. tick is high for one cycle when the counter equals all-ones; the counter then wraps to 0. The counter is unaffected by bus traffic.
- Outputs change only on commit or reset.

Optional Feature:
- Macro: LCD_ZBLANK_EN.
- Defined: m1/m2 outputs are the committed masks ANDed with a leading-zero blank mask computed per row at commit time.
  - Scanning runs from nibble 15 down to 1; each leading nibble equal to 0 is cleared.
  - Scanning stops at the first nonzero nibble; nibble 0 is never blanked.
  - Reads of addresses 8/9 still return the unmodified shadows.
- Undefined: masks pass through unmodified; no blanking logic is synthesised.

Decomposition:
- Shared package lcd_pkg holds:
  - address constants ADR_ROW1_0..ADR_ROW2_3, ADR_M1, ADR_M2, ADR_CTRL, ADR_STAT
  - ctrl bit indices CTRL_COMMIT=0, CTRL_AUTO=1
  - STAT_PEND=0
  - nibble/row width constants
- Sub-module lcd_zblank (64-bit row in, 16-bit mask out, combinational) exists only under LCD_ZBLANK_EN and is instantiated twice.

Test Plan:
- Reset: hold rst_ low 3 cycles mid-read of addr 0 -> no ack; f1=f2=0, m1=m2=0, ctrl reads 16'h0002, status reads 0.
- Byte lanes: write 16'h1234 to addr 0 sel=11, then 16'hAB00 sel=10 -> read addr 0 returns 16'hAB34, status=1, f1 unchanged.
- Explicit commit: write ctrl=16'h0001 with AUTO cleared -> f1[15:0]=16'hAB34 on the next edge, status=0, ctrl reads 16'h0000.
- Auto commit (REFRESH_DIV=4): write m1=16'hFFFF -> m1 output updates exactly on the edge after counter=15; with AUTO=0, m1 never updates.
- Collision: data write to addr 4 in the same cycle as a tick commit -> f2 keeps its old value, status stays 1, the next tick commits it.
- LCD_ZBLANK_EN: f1=64'h0000_0000_0000_00A0, m1=16'hFFFF committed -> m1 output=16'h0003. f1=0 -> m1 output=16'h0001.
